// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution checker.
//   q_entry_t         : one recorded prediction {addr, taken, target}
//   state_t           : checker FSM states (RUN, FLUSH)
//   DELAY_SLOT_OFFSET : fall-through distance past a branch and its delay slot
package branch_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        taken;
      logic [31:0] target;
   } q_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

endpackage

// File: rtl/branch_resolve_checker_pred_queue.sv
// In-order queue of predictions waiting for resolution.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_entry at the tail (ignored when full or flushing)
//   push_entry  : prediction to record
//   pop         : drop the head entry (ignored when empty)
//   flush       : discard every entry; overrides push and pop
//   head        : oldest entry (meaningless while empty)
//   full, empty : occupancy flags from the registered pointers
module pred_queue
   import branch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  q_entry_t push_entry,
   input  logic     pop,
   input  logic     flush,
   output q_entry_t head,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

   q_entry_t    mem_q [DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] occ;

   assign occ   = wr_ptr_q - rd_ptr_q;
   assign full  = (occ == FULL_OCC);
   assign empty = (occ == '0);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only observed between push and pop.
   always_ff @(posedge clk) begin
      if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/branch_resolve_checker.sv
// Checks fetch-stage branch predictions against execute-stage outcomes.
//   CLK, RESET                       : clock, asynchronous active-low reset
//   Pred_valid/addr/taken/target     : prediction recorded at fetch
//   Pred_ready                       : queue can accept a prediction
//   Res_valid/addr/taken/target      : outcome resolved in execute
//   Mispredict, Redirect_addr        : one-cycle flush pulse and correct fetch address
//   Update_valid/addr/taken          : predictor training strobe
//   Order_error                      : sticky resolution-order violation
//   Branch_count, Mispredict_count   : saturating statistics
module branch_resolve_checker
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Pred_valid,
   input  logic [31:0]      Pred_addr,
   input  logic             Pred_taken,
   input  logic [31:0]      Pred_target,
   output logic             Pred_ready,
   input  logic             Res_valid,
   input  logic [31:0]      Res_addr,
   input  logic             Res_taken,
   input  logic [31:0]      Res_target,
   output logic             Mispredict,
   output logic [31:0]      Redirect_addr,
   output logic             Update_valid,
   output logic [31:0]      Update_addr,
   output logic             Update_taken,
   output logic             Order_error,
   output logic [CNT_W-1:0] Branch_count,
   output logic [CNT_W-1:0] Mispredict_count
);

   state_t           state_q, state_d;
   logic             mispredict_q, mispredict_d;
   logic [31:0]      redirect_addr_q, redirect_addr_d;
   logic             update_valid_q, update_valid_d;
   logic [31:0]      update_addr_q, update_addr_d;
   logic             update_taken_q, update_taken_d;
   logic             order_error_q, order_error_d;
   logic [CNT_W-1:0] branch_count_q, branch_count_d;
   logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

   q_entry_t head;
   q_entry_t push_entry;
   logic     q_full, q_empty;
   logic     in_run, res_hit, res_bad, mismatch, do_push, do_pop;

   assign in_run     = (state_q == RUN);
   // Registered occupancy only: a same-cycle pop does not open a slot.
   assign Pred_ready = in_run && !q_full;

   assign res_hit  = in_run && Res_valid && !q_empty && (Res_addr == head.addr);
   assign res_bad  = in_run && Res_valid && (q_empty || (Res_addr != head.addr));
   assign mismatch = res_hit &&
                     ((Res_taken != head.taken) || (Res_taken && (Res_target != head.target)));
   // Anything fetched alongside a mispredict is wrong-path, so it is dropped.
   assign do_push  = Pred_valid && Pred_ready && !mismatch;
   assign do_pop   = res_hit && !mismatch;

   assign push_entry = '{addr: Pred_addr, taken: Pred_taken, target: Pred_target};

   pred_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (CLK),
      .rst_n      (RESET),
      .push       (do_push),
      .push_entry (push_entry),
      .pop        (do_pop),
      .flush      (mismatch),
      .head       (head),
      .full       (q_full),
      .empty      (q_empty)
   );

   always_comb begin
      state_d            = RUN;
      mispredict_d       = mismatch;
      redirect_addr_d    = redirect_addr_q;
      update_valid_d     = res_hit;
      update_addr_d      = update_addr_q;
      update_taken_d     = update_taken_q;
      order_error_d      = order_error_q || res_bad;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;

      if (in_run && mismatch) state_d = FLUSH;

      if (res_hit) begin
         update_addr_d  = Res_addr;
         update_taken_d = Res_taken;
         if (branch_count_q != '1) branch_count_d = branch_count_q + 1'b1;
      end

      if (mismatch) begin
         redirect_addr_d = Res_taken ? Res_target : (Res_addr + DELAY_SLOT_OFFSET);
         if (mispredict_count_q != '1) mispredict_count_d = mispredict_count_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q            <= RUN;
         mispredict_q       <= 1'b0;
         redirect_addr_q    <= '0;
         update_valid_q     <= 1'b0;
         update_addr_q      <= '0;
         update_taken_q     <= 1'b0;
         order_error_q      <= 1'b0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         state_q            <= state_d;
         mispredict_q       <= mispredict_d;
         redirect_addr_q    <= redirect_addr_d;
         update_valid_q     <= update_valid_d;
         update_addr_q      <= update_addr_d;
         update_taken_q     <= update_taken_d;
         order_error_q      <= order_error_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign Mispredict       = mispredict_q;
   assign Redirect_addr    = redirect_addr_q;
   assign Update_valid     = update_valid_q;
   assign Update_addr      = update_addr_q;
   assign Update_taken     = update_taken_q;
   assign Order_error      = order_error_q;
   assign Branch_count     = branch_count_q;
   assign Mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_checker.sv
// Directed bench for branch_resolve_checker: one task per scenario,
// inputs changed 1 time unit after the rising edge, outputs sampled there too.
module tb_branch_resolve_checker;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        Pred_valid = 1'b0;
   logic [31:0] Pred_addr = '0;
   logic        Pred_taken = 1'b0;
   logic [31:0] Pred_target = '0;
   logic        Pred_ready;
   logic        Res_valid = 1'b0;
   logic [31:0] Res_addr = '0;
   logic        Res_taken = 1'b0;
   logic [31:0] Res_target = '0;
   logic        Mispredict;
   logic [31:0] Redirect_addr;
   logic        Update_valid;
   logic [31:0] Update_addr;
   logic        Update_taken;
   logic        Order_error;
   logic [31:0] Branch_count;
   logic [31:0] Mispredict_count;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   branch_resolve_checker #(.DEPTH(4), .CNT_W(32)) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .Pred_valid       (Pred_valid),
      .Pred_addr        (Pred_addr),
      .Pred_taken       (Pred_taken),
      .Pred_target      (Pred_target),
      .Pred_ready       (Pred_ready),
      .Res_valid        (Res_valid),
      .Res_addr         (Res_addr),
      .Res_taken        (Res_taken),
      .Res_target       (Res_target),
      .Mispredict       (Mispredict),
      .Redirect_addr    (Redirect_addr),
      .Update_valid     (Update_valid),
      .Update_addr      (Update_addr),
      .Update_taken     (Update_taken),
      .Order_error      (Order_error),
      .Branch_count     (Branch_count),
      .Mispredict_count (Mispredict_count)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      Pred_valid = 1'b0;
      Res_valid  = 1'b0;
      RESET      = 1'b0;
      step();
      step();
      RESET = 1'b1;
      step();
   endtask

   task automatic push(input logic [31:0] a, input logic t, input logic [31:0] tg);
      Pred_valid = 1'b1; Pred_addr = a; Pred_taken = t; Pred_target = tg;
      step();
      Pred_valid = 1'b0;
   endtask

   task automatic resolve(input logic [31:0] a, input logic t, input logic [31:0] tg);
      Res_valid = 1'b1; Res_addr = a; Res_taken = t; Res_target = tg;
      step();
      Res_valid = 1'b0;
   endtask

   task automatic test_reset();
      step();
      total++;
      if ({Pred_ready, Mispredict, Update_valid, Order_error} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=1000", {Pred_ready, Mispredict, Update_valid, Order_error});
      end
      total++;
      if ({Branch_count, Mispredict_count, Redirect_addr, Update_addr} !== 128'd0) begin
         bad++;
         $display("FAIL reset_values bc=%0d mc=%0d redir=%h uaddr=%h want all 0",
                  Branch_count, Mispredict_count, Redirect_addr, Update_addr);
      end
      $display("reset: Pred_ready=%b Branch_count=%0d", Pred_ready, Branch_count);
   endtask

   task automatic test_not_taken();
      apply_reset();
      push(32'h100, 1'b0, 32'hDEAD);
      resolve(32'h100, 1'b0, 32'h0);
      total++;
      if ({Update_valid, Update_addr, Update_taken, Mispredict} !== {1'b1, 32'h100, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL nt_update got v=%b a=%h t=%b m=%b want v=1 a=100 t=0 m=0",
                  Update_valid, Update_addr, Update_taken, Mispredict);
      end
      total++;
      if (Branch_count !== 32'd1) begin
         bad++;
         $display("FAIL nt_branch_count got=%0d want=1", Branch_count);
      end
      step();
      total++;
      if (Update_valid !== 1'b0) begin
         bad++;
         $display("FAIL nt_update_pulse got=%b want=0", Update_valid);
      end
      $display("not_taken: addr=%h bc=%0d", Update_addr, Branch_count);
   endtask

   task automatic test_dir_mispredict();
      apply_reset();
      push(32'h200, 1'b0, 32'h0);
      push(32'h210, 1'b0, 32'h0);
      resolve(32'h200, 1'b1, 32'h400);
      total++;
      if ({Mispredict, Redirect_addr, Pred_ready} !== {1'b1, 32'h400, 1'b0}) begin
         bad++;
         $display("FAIL dir_flush got m=%b redir=%h rdy=%b want m=1 redir=400 rdy=0",
                  Mispredict, Redirect_addr, Pred_ready);
      end
      total++;
      if ({Mispredict_count, Branch_count, Update_taken} !== {32'd1, 32'd1, 1'b1}) begin
         bad++;
         $display("FAIL dir_counts got mc=%0d bc=%0d ut=%b want mc=1 bc=1 ut=1",
                  Mispredict_count, Branch_count, Update_taken);
      end
      // FLUSH cycle: both requests must be ignored.
      Res_valid = 1'b1; Res_addr = 32'h999; Res_taken = 1'b0;
      Pred_valid = 1'b1; Pred_addr = 32'hAAA; Pred_taken = 1'b0;
      step();
      Res_valid = 1'b0; Pred_valid = 1'b0;
      total++;
      if ({Pred_ready, Mispredict, Order_error, Update_valid} !== 4'b1000) begin
         bad++;
         $display("FAIL dir_after_flush got rdy=%b m=%b oe=%b uv=%b want 1 0 0 0",
                  Pred_ready, Mispredict, Order_error, Update_valid);
      end
      resolve(32'h210, 1'b0, 32'h0);
      total++;
      if ({Order_error, Update_valid, Branch_count} !== {1'b1, 1'b0, 32'd1}) begin
         bad++;
         $display("FAIL dir_stale_res got oe=%b uv=%b bc=%0d want oe=1 uv=0 bc=1",
                  Order_error, Update_valid, Branch_count);
      end
      $display("dir_mispredict: mc=%0d oe=%b", Mispredict_count, Order_error);
   endtask

   task automatic test_target_and_wrap();
      apply_reset();
      push(32'h300, 1'b1, 32'h500);
      resolve(32'h300, 1'b1, 32'h504);
      total++;
      if ({Mispredict, Redirect_addr} !== {1'b1, 32'h504}) begin
         bad++;
         $display("FAIL target_redirect got m=%b redir=%h want m=1 redir=504", Mispredict, Redirect_addr);
      end
      step();
      push(32'hFFFF_FFFC, 1'b0, 32'h0);
      resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
      total++;
      if ({Mispredict, Update_valid, Order_error} !== 3'b010) begin
         bad++;
         $display("FAIL wrap_nt got m=%b uv=%b oe=%b want 0 1 0", Mispredict, Update_valid, Order_error);
      end
      push(32'hFFFF_FFFC, 1'b1, 32'h10);
      resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
      total++;
      if ({Mispredict, Redirect_addr, Mispredict_count} !== {1'b1, 32'h4, 32'd2}) begin
         bad++;
         $display("FAIL wrap_redirect got m=%b redir=%h mc=%0d want m=1 redir=4 mc=2",
                  Mispredict, Redirect_addr, Mispredict_count);
      end
      $display("target_wrap: redir=%h mc=%0d bc=%0d", Redirect_addr, Mispredict_count, Branch_count);
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
      total++;
      if (Pred_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_ready got=%b want=0", Pred_ready);
      end
      push(32'h2000, 1'b0, 32'h0);
      // Correct resolution together with a push while full: push is refused.
      Pred_valid = 1'b1; Pred_addr = 32'h3000; Pred_taken = 1'b0;
      Res_valid = 1'b1; Res_addr = 32'h1000; Res_taken = 1'b0;
      step();
      Pred_valid = 1'b0; Res_valid = 1'b0;
      total++;
      if ({Update_valid, Pred_ready, Mispredict} !== 3'b110) begin
         bad++;
         $display("FAIL full_pop_push got uv=%b rdy=%b m=%b want 1 1 0", Update_valid, Pred_ready, Mispredict);
      end
      for (int i = 1; i < 4; i++) begin
         resolve(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
         total++;
         if ({Update_valid, Update_addr, Order_error} !== {1'b1, 32'h1000 + 32'(4 * i), 1'b0}) begin
            bad++;
            $display("FAIL full_drain%0d got uv=%b a=%h oe=%b want uv=1 a=%h oe=0",
                     i, Update_valid, Update_addr, Order_error, 32'h1000 + 32'(4 * i));
         end
      end
      // Neither refused push may have been stored.
      resolve(32'h2000, 1'b0, 32'h0);
      total++;
      if ({Order_error, Branch_count} !== {1'b1, 32'd4}) begin
         bad++;
         $display("FAIL full_no_extra got oe=%b bc=%0d want oe=1 bc=4", Order_error, Branch_count);
      end
      $display("full: bc=%0d oe=%b", Branch_count, Order_error);
   endtask

   task automatic test_violation();
      apply_reset();
      resolve(32'h500, 1'b0, 32'h0);
      total++;
      if ({Order_error, Update_valid, Branch_count} !== {1'b1, 1'b0, 32'd0}) begin
         bad++;
         $display("FAIL viol_empty got oe=%b uv=%b bc=%0d want oe=1 uv=0 bc=0",
                  Order_error, Update_valid, Branch_count);
      end
      push(32'h700, 1'b0, 32'h0);
      resolve(32'h704, 1'b0, 32'h0);
      total++;
      if ({Update_valid, Branch_count} !== {1'b0, 32'd0}) begin
         bad++;
         $display("FAIL viol_addr got uv=%b bc=%0d want uv=0 bc=0", Update_valid, Branch_count);
      end
      resolve(32'h700, 1'b0, 32'h0);
      total++;
      if ({Update_valid, Branch_count, Order_error} !== {1'b1, 32'd1, 1'b1}) begin
         bad++;
         $display("FAIL viol_sticky got uv=%b bc=%0d oe=%b want uv=1 bc=1 oe=1",
                  Update_valid, Branch_count, Order_error);
      end
      RESET = 1'b0;
      #1;
      total++;
      if (Order_error !== 1'b0) begin
         bad++;
         $display("FAIL viol_reset_clear got=%b want=0", Order_error);
      end
      $display("violation: oe cleared by reset=%b", !Order_error);
   endtask

   task automatic test_reset_mid_flush();
      apply_reset();
      push(32'h800, 1'b0, 32'h0);
      resolve(32'h800, 1'b1, 32'h900);
      total++;
      if ({Mispredict, Pred_ready} !== 2'b10) begin
         bad++;
         $display("FAIL mid_flush_enter got m=%b rdy=%b want m=1 rdy=0", Mispredict, Pred_ready);
      end
      #2;
      RESET = 1'b0;
      #1;
      total++;
      if ({Mispredict, Pred_ready, Branch_count, Mispredict_count} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
         bad++;
         $display("FAIL mid_flush_reset got m=%b rdy=%b bc=%0d mc=%0d want m=0 rdy=1 bc=0 mc=0",
                  Mispredict, Pred_ready, Branch_count, Mispredict_count);
      end
      step();
      RESET = 1'b1;
      step();
      $display("reset_mid_flush: rdy=%b", Pred_ready);
   endtask

   initial begin
      test_reset();
      test_not_taken();
      test_dir_mispredict();
      test_target_and_wrap();
      test_full();
      test_violation();
      test_reset_mid_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_resolve_checker.md
Name: branch_resolve_checker

Overview:
- Resolution-side counterpart of the fetch-stage branch predictor in the MIPS pipeline.
- Records each prediction issued at fetch in an in-order queue, then checks it against the outcome resolved in execute.
- On a wrong prediction: pulses a mispredict/flush with the corrected fetch address.
- On every resolution: drives the predictor's training inputs and maintains branch and mispredict statistics counters.

Parameters:
- DEPTH, 4: maximum in-flight predicted branches; power of two, at least 2.
- CNT_W, 32: width of the statistics counters.

Ports:
- CLK  in  1  pipeline clock.
- RESET  in  1  asynchronous, active-low reset.
- Pred_valid  in  1  fetch records a prediction this cycle.
- Pred_addr  in  32  address of the branch instruction.
- Pred_taken  in  1  predicted direction.
- Pred_target  in  32  predicted target; ignored when Pred_taken=0.
- Pred_ready  out  1  queue can accept a prediction.
- Res_valid  in  1  execute has resolved a branch this cycle.
- Res_addr  in  32  address of the resolved branch.
- Res_taken  in  1  actual direction.
- Res_target  in  32  actual target; ignored when Res_taken=0.
- Mispredict  out  1  one-cycle flush pulse.
- Redirect_addr  out  32  correct fetch address; valid while Mispredict=1.
- Update_valid  out  1  training strobe to the predictor's Branch_resolved.
- Update_addr  out  32  drives the predictor's Branch_resolved_addr.
- Update_taken  out  1  actual direction for training.
- Order_error  out  1  sticky protocol-violation flag.
- Branch_count  out  CNT_W  resolved branches.
- Mispredict_count  out  CNT_W  mispredicted branches.

Behaviour:
- Reset (RESET=0, asynchronous):
  - Queue empty; FSM in RUN.
  - All outputs 0 except Pred_ready=1.
  - Counters 0; Order_error cleared.
  - Reset asserted mid-flush aborts the flush immediately.
- Queue:
  - Circular buffer of {addr, taken, target}, DEPTH entries.
  - Read/write pointers carry one wrap bit; occupancy is log2(DEPTH)+1 bits.
- Push: Pred_valid && Pred_ready writes at the tail.
- Pred_ready = !full && state==RUN.
  - Decided from the registered occupancy, so a same-cycle pop does not free space.
- Resolution, when Res_valid=1, queue non-empty and Res_addr == head.addr:
  - Pop the head.
  - Mismatch = (Res_taken != head.taken) || (Res_taken && Res_target != head.target).
- Registered outputs, all one cycle after Res_valid:
  - Update_valid=1 for one cycle; Update_addr=Res_addr; Update_taken=Res_taken.
  - Branch_count increments.
- On Mismatch:
  - Mispredict=1 for one cycle.
  - Redirect_addr = Res_taken ? Res_target : Res_addr+8, covering branch plus delay slot; wraps modulo 2^32.
  - Mispredict_count increments.
  - The entire queue is cleared (all younger entries are wrong-path).
  - A push in the same cycle is discarded.
  - FSM goes RUN -> FLUSH.
- FLUSH lasts exactly one cycle:
  - Pred_ready=0; Pred_valid is ignored; Res_valid is ignored and does not set Order_error.
  - FLUSH -> RUN unconditionally.
- Protocol violation: Res_valid in RUN with an empty queue, or with Res_addr != head.addr.
  - Order_error set and held until reset.
  - No pop, no Update_valid, no Mispredict, counters unchanged.
- Simultaneous push and correct resolution in RUN (not full): both occur; occupancy unchanged.
- Counters saturate at all-ones; no wrap.
- Outputs other than Pred_ready are registered; Pred_ready is combinational from state and occupancy.

Decomposition:
- Shared package (branch_pkg):
  - Queue-entry struct {addr[31:0], taken, target[31:0]}.
  - FSM enum {RUN, FLUSH}.
  - Delay-slot offset constant DELAY_SLOT_OFFSET=8.
- Sub-module pred_queue: parameterised FIFO with push, pop, flush-all, head view, full/empty.
- This block keeps the compare, FSM, output registers and counters.

Test Plan:
- Not-taken predicted, not-taken resolved: push {0x100,0,x}, then Res {0x100,0} -> cycle after: Update_valid=1, Update_addr=0x100, Update_taken=0, Mispredict=0, Branch_count=1.
- Direction mispredict:
  - Push 0x200 (NT) and 0x210 (NT); Res {0x200, taken, 0x400}.
  - -> Mispredict=1, Redirect_addr=0x400, Mispredict_count=1, queue empty, Pred_ready=0 for one cycle then 1.
  - A following Res 0x210 sets Order_error.
- Target mispredict and redirect wrap:
  - Pred {0x300,1,0x500}, Res {0x300,1,0x504} -> Redirect 0x504.
  - Pred NT at 0xFFFFFFFC, Res NT -> no flush.
  - Pred taken at 0xFFFFFFFC, Res NT -> Redirect_addr=0x00000004.
- Full queue:
  - Push 4 entries -> Pred_ready=0; a 5th Pred_valid is not stored.
  - Resolve head correctly together with Pred_valid -> push rejected that cycle, Pred_ready=1 next cycle.
- Protocol violations: Res_valid with empty queue -> Order_error=1, Branch_count unchanged; Order_error stays 1 until RESET=0.
- Reset mid-flush: assert RESET=0 asynchronously in the FLUSH cycle -> state RUN, counters 0, Pred_ready=1 immediately, Mispredict=0.
